// File: rtl/up_dn_sweep_ctrl.sv
// Sequencer driving an external up/down counter through sawtooth or triangle sweeps
// between latched bounds, with a dwell at each bound and an optional sweep limit.
module up_dn_sweep_ctrl #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned DWELL_W = 4,
  parameter int unsigned SWP_W   = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               stop,
  input  logic [1:0]         mode,
  input  logic [WIDTH-1:0]   lo,
  input  logic [WIDTH-1:0]   hi,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [SWP_W-1:0]   sweeps,
  input  logic [WIDTH-1:0]   cnt,
  output logic               cnt_en,
  output logic               up_dnb,
  output logic               load,
  output logic [WIDTH-1:0]   load_val,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [SWP_W-1:0]   swp_cnt
);

  localparam logic [1:0] MODE_SAW_DN = 2'd1;
  localparam logic [1:0] MODE_TRI    = 2'd2;
  localparam logic [1:0] MODE_RSVD   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RUN_UP = 3'd2,
    S_RUN_DN = 3'd3,
    S_DWELL  = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [SWP_W-1:0]   sweeps_q, sweeps_d;
  logic [DWELL_W-1:0] timer_q, timer_d;
  logic               at_hi_q, at_hi_d;
  logic [SWP_W-1:0]   swp_cnt_q, swp_cnt_d;
  logic               load_q, load_d;
  logic [WIDTH-1:0]   load_val_q, load_val_d;
  logic               up_dnb_q, up_dnb_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               cnt_en_c;
  logic [SWP_W-1:0]   swp_inc;

  // Completed-sweep count, saturating at all-ones
  assign swp_inc = (&swp_cnt_q) ? swp_cnt_q : swp_cnt_q + SWP_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      mode_q     <= '0;
      lo_q       <= '0;
      hi_q       <= '0;
      dwell_q    <= '0;
      sweeps_q   <= '0;
      timer_q    <= '0;
      at_hi_q    <= 1'b0;
      swp_cnt_q  <= '0;
      load_q     <= 1'b0;
      load_val_q <= '0;
      up_dnb_q   <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      dwell_q    <= dwell_d;
      sweeps_q   <= sweeps_d;
      timer_q    <= timer_d;
      at_hi_q    <= at_hi_d;
      swp_cnt_q  <= swp_cnt_d;
      load_q     <= load_d;
      load_val_q <= load_val_d;
      up_dnb_q   <= up_dnb_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    dwell_d    = dwell_q;
    sweeps_d   = sweeps_q;
    timer_d    = timer_q;
    at_hi_d    = at_hi_q;
    swp_cnt_d  = swp_cnt_q;
    load_val_d = load_val_q;
    up_dnb_d   = up_dnb_q;
    err_d      = 1'b0;
    cnt_en_c   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          if ((lo > hi) || (mode == MODE_RSVD)) begin
            err_d = 1'b1;
          end else begin
            mode_d    = mode;
            lo_d      = lo;
            hi_d      = hi;
            dwell_d   = dwell;
            sweeps_d  = sweeps;
            swp_cnt_d = '0;
            state_d   = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        state_d = (mode_q == MODE_SAW_DN) ? S_RUN_DN : S_RUN_UP;
      end
      S_RUN_UP: begin
        if (cnt == hi_q) begin
          state_d = S_DWELL;
          timer_d = dwell_q;
          at_hi_d = 1'b1;
        end else begin
          cnt_en_c = 1'b1;
        end
      end
      S_RUN_DN: begin
        if (cnt == lo_q) begin
          state_d = S_DWELL;
          timer_d = dwell_q;
          at_hi_d = 1'b0;
        end else begin
          cnt_en_c = 1'b1;
        end
      end
      S_DWELL: begin
        if (timer_q != '0) begin
          timer_d = timer_q - DWELL_W'(1);
        end else if ((mode_q == MODE_TRI) && at_hi_q) begin
          // Triangle turns around at hi; only the return to lo completes a sweep
          state_d = S_RUN_DN;
        end else begin
          swp_cnt_d = swp_inc;
          if ((sweeps_q != '0) && (swp_inc == sweeps_q)) begin
            state_d = S_DONE;
          end else if (mode_q == MODE_TRI) begin
            state_d = S_RUN_UP;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides everything outside IDLE, including a coincident sweep completion
    if (stop && (state_q != S_IDLE)) begin
      state_d   = S_IDLE;
      cnt_en_c  = 1'b0;
      swp_cnt_d = swp_cnt_q;
    end

    // Registered outputs describe the state being entered
    load_d = (state_d == S_LOAD);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    case (state_d)
      S_LOAD: begin
        load_val_d = (mode_d == MODE_SAW_DN) ? hi_d : lo_d;
        up_dnb_d   = (mode_d != MODE_SAW_DN);
      end
      S_RUN_UP: up_dnb_d = 1'b1;
      S_RUN_DN: up_dnb_d = 1'b0;
      default:  up_dnb_d = up_dnb_q;
    endcase
  end

  assign cnt_en   = cnt_en_c;
  // Abort must suppress a pending load within the same cycle
  assign load     = load_q & ~stop;
  assign load_val = load_val_q;
  assign up_dnb   = up_dnb_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign swp_cnt  = swp_cnt_q;

endmodule
